// File: rtl/onehot_dec_pkg.sv
// Shared constants and helpers for the pipelined one-hot decoder.
// The decode helper works at a fixed maximum width, and callers slice the result down to O bits.
package onehot_dec_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int DEC_MAX_C  = 8;
  localparam int DEC_MAX_O  = 1 << DEC_MAX_C;

  function automatic int onehot_w(input int c);
    return 1 << c;
  endfunction

  function automatic logic [DEC_MAX_O-1:0] decode(input logic [DEC_MAX_C-1:0] sel,
                                                  input logic                 en);
    logic [DEC_MAX_O-1:0] v;
    v = '0;
    if (en) v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec_skid.sv
// Generic 2-entry valid/ready skid buffer with FIFO order.
// in_ready depends only on registered occupancy, never on out_ready.
module onehot_dec_skid
  import onehot_dec_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  localparam int CW = $clog2(SKID_DEPTH + 1);

  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          push, pop;

  assign in_ready  = (count_q < CW'(SKID_DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == '0) head_d = in_data;
        else               tail_d = in_data;
        count_d = count_q + 1'b1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 1'b1;
      end
      2'b11: begin
        if (count_q == CW'(1)) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-high.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // NOTE: data slots are not reset; occupancy alone says whether they hold anything.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: rtl/onehot_dec_pipe.sv
// Multi-channel registered binary-to-one-hot decoder with skid buffer and sticky hit mask.
// Optional illegal-select detection is enabled by defining ONEHOT_DEC_ERR_EN.
module onehot_dec_pipe
  import onehot_dec_pkg::*;
#(
  parameter  int C     = 3,
  parameter  int N_CH  = 2,
  localparam int O     = onehot_w(C),
  parameter  int LEGAL = O
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_CH*C-1:0]   in_sel,
  input  logic [N_CH-1:0]     in_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_CH*O-1:0]   out_onehot,
  output logic [N_CH-1:0]     out_any,
  input  logic                mask_clr,
  output logic [N_CH*O-1:0]   hit_mask,
  output logic [N_CH-1:0]     err
);

  localparam int DW = N_CH*O + 2*N_CH;

  if (C < 1 || C > DEC_MAX_C || N_CH < 1 || LEGAL < 1 || LEGAL > O) begin : g_bad_params
    $error("onehot_dec_pipe: illegal parameter combination");
  end

  logic [N_CH*O-1:0]    dec_onehot;
  logic [N_CH-1:0]      dec_any;
  logic [N_CH-1:0]      dec_err;
  logic [DEC_MAX_C-1:0] sel_ext;
  logic [DEC_MAX_O-1:0] dec_full;
  logic                 illegal;

  always_comb begin
    dec_onehot = '0;
    dec_any    = '0;
    dec_err    = '0;
    sel_ext    = '0;
    dec_full   = '0;
    illegal    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      sel_ext        = '0;
      sel_ext[C-1:0] = in_sel[k*C +: C];
`ifdef ONEHOT_DEC_ERR_EN
      illegal = in_en[k] && (32'(sel_ext) >= 32'(LEGAL));
`else
      illegal = 1'b0;
`endif
      // An illegal code decodes as if disabled, so it can never reach hit_mask.
      dec_full              = decode(sel_ext, in_en[k] & ~illegal);
      dec_onehot[k*O +: O]  = dec_full[O-1:0];
      dec_any[k]            = |dec_full[O-1:0];
      dec_err[k]            = illegal;
    end
  end

  logic [DW-1:0] skid_in, skid_out;
  logic          skid_valid;

  assign skid_in = {dec_err, dec_any, dec_onehot};

  onehot_dec_skid #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (skid_in),
    .out_valid (skid_valid),
    .out_ready (out_ready),
    .out_data  (skid_out)
  );

  // Unreset slot contents are masked so the outputs read zero while empty.
  always_comb begin
    out_valid  = skid_valid;
    out_onehot = '0;
    out_any    = '0;
    err        = '0;
    if (skid_valid) begin
      out_onehot = skid_out[N_CH*O-1:0];
      out_any    = skid_out[N_CH*O +: N_CH];
      err        = skid_out[N_CH*O+N_CH +: N_CH];
    end
  end

  logic [N_CH*O-1:0] hit_mask_q, hit_mask_d;
  logic              pop;

  assign pop      = skid_valid & out_ready;
  assign hit_mask = hit_mask_q;

  always_comb begin
    hit_mask_d = (mask_clr ? '0 : hit_mask_q) | (pop ? out_onehot : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) hit_mask_q <= '0;
    else     hit_mask_q <= hit_mask_d;
  end

endmodule

// File: tb/tb_onehot_dec_pipe.sv
// Directed self-checking bench for onehot_dec_pipe with C=2, N_CH=2, LEGAL=3.
// Expected values adapt to whether ONEHOT_DEC_ERR_EN is defined.
module tb_onehot_dec_pipe;

  localparam int C    = 2;
  localparam int N_CH = 2;
  localparam int O    = 4;

`ifdef ONEHOT_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, mask_clr;
  logic [3:0] in_sel;
  logic [1:0] in_en;
  logic [7:0] out_onehot, hit_mask;
  logic [1:0] out_any, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_dec_pipe #(.C(C), .N_CH(N_CH), .LEGAL(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_any    (out_any),
    .mask_clr   (mask_clr),
    .hit_mask   (hit_mask),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] sel, input logic [1:0] en);
    in_valid = v;
    in_sel   = sel;
    in_en    = en;
  endtask

  typedef struct {
    logic [3:0] sel;
    logic [1:0] en;
    logic [7:0] exp_oh;
    logic [1:0] exp_any;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // sel = {ch1, ch0}; one-hot = {ch1[3:0], ch0[3:0]}
    vecs[0] = '{4'b01_11, 2'b11, ERR_EN ? 8'b0010_0000 : 8'b0010_1000,
                ERR_EN ? 2'b10 : 2'b11, ERR_EN ? 2'b01 : 2'b00};
    vecs[1] = '{4'b10_00, 2'b01, 8'b0000_0001, 2'b01, 2'b00};
    vecs[2] = '{4'b00_10, 2'b10, 8'b0001_0000, 2'b10, 2'b00};
    vecs[3] = '{4'b11_01, 2'b11, ERR_EN ? 8'b0000_0010 : 8'b1000_0010,
                ERR_EN ? 2'b01 : 2'b11, ERR_EN ? 2'b10 : 2'b00};
    vecs[4] = '{4'b11_11, 2'b00, 8'b0000_0000, 2'b00, 2'b00};
    vecs[5] = '{4'b10_10, 2'b11, 8'b0100_0100, 2'b11, 2'b00};

    rst = 1'b1; mask_clr = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'b0, 2'b0);
    tick(); tick();
    rst = 1'b0;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_onehot", 32'(out_onehot), 32'd0);
    check("reset out_any", 32'(out_any), 32'd0);
    check("reset hit_mask", 32'(hit_mask), 32'd0);
    check("reset err", 32'(err), 32'd0);
    tick();
    check("in_ready after reset", 32'(in_ready), 32'd1);

    // Streaming at full rate: each beat appears the cycle after it is accepted.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].sel, vecs[i].en);
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d out_onehot", i), 32'(out_onehot), 32'(vecs[i].exp_oh));
      check($sformatf("vec%0d out_any", i), 32'(out_any), 32'(vecs[i].exp_any));
      check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
    end
    drive(1'b0, 4'b0, 2'b0);
    tick();
    check("drain out_valid", 32'(out_valid), 32'd0);

    // Backpressure: A, B fill the buffer, C is held off until space frees.
    out_ready = 1'b0;
    drive(1'b1, 4'b00_00, 2'b01);
    tick();
    check("bp A out_onehot", 32'(out_onehot), 32'h01);
    check("bp in_ready after A", 32'(in_ready), 32'd1);
    drive(1'b1, 4'b00_01, 2'b01);
    tick();
    check("bp full in_ready", 32'(in_ready), 32'd0);
    check("bp A held", 32'(out_onehot), 32'h01);
    drive(1'b1, 4'b00_10, 2'b01);
    tick();
    check("bp C refused in_ready", 32'(in_ready), 32'd0);
    check("bp A still held", 32'(out_onehot), 32'h01);
    check("bp valid held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp pop B", 32'(out_onehot), 32'h02);
    check("bp in_ready reopens", 32'(in_ready), 32'd1);
    tick();
    check("bp pop C", 32'(out_onehot), 32'h04);
    drive(1'b0, 4'b0, 2'b0);
    tick();
    check("bp empty", 32'(out_valid), 32'd0);

    // Sticky hit mask.
    mask_clr = 1'b1;
    tick();
    mask_clr = 1'b0;
    check("mask cleared", 32'(hit_mask), 32'h00);
    drive(1'b1, 4'b00_00, 2'b01);
    tick();
    drive(1'b1, 4'b00_10, 2'b01);
    tick();
    check("mask after code0", 32'(hit_mask), 32'h01);
    drive(1'b0, 4'b0, 2'b0);
    tick();
    check("mask codes 0,2", 32'(hit_mask), 32'h05);
    drive(1'b1, 4'b00_11, 2'b01);
    tick();
    check("code3 err", 32'(err), ERR_EN ? 32'd1 : 32'd0);
    check("code3 onehot", 32'(out_onehot), ERR_EN ? 32'h00 : 32'h08);
    drive(1'b0, 4'b0, 2'b0);
    tick();
    check("mask after code3", 32'(hit_mask), ERR_EN ? 32'h05 : 32'h0D);
    drive(1'b1, 4'b00_11, 2'b01);
    tick();
    drive(1'b0, 4'b0, 2'b0);
    mask_clr = 1'b1;
    tick();
    mask_clr = 1'b0;
    check("mask clr with pop", 32'(hit_mask), ERR_EN ? 32'h00 : 32'h08);

    // Reset with two beats buffered.
    out_ready = 1'b0;
    drive(1'b1, 4'b01_00, 2'b11);
    tick();
    drive(1'b1, 4'b10_01, 2'b11);
    tick();
    check("pre-reset full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    drive(1'b0, 4'b0, 2'b0);
    tick();
    rst = 1'b0;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset hit_mask", 32'(hit_mask), 32'h00);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    check("mid reset out_onehot", 32'(out_onehot), 32'h00);
    out_ready = 1'b1;
    tick();
    check("beats dropped", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_dec_pipe.md
Name: onehot_dec_pipe

Overview:
- Parametrised, multi-channel, registered binary-to-one-hot decoder.
- Each channel decodes a C-bit select into an O = 2^C one-hot vector. O is a localparam derived from C in the parameter port list.
- Adds a valid/ready stream interface with a 2-entry skid buffer and a sticky per-channel hit mask.
- Sits between a select-producing front end and wide one-hot consumers such as bank enables and grant vectors.

Parameters:
- C, 3, select width per channel; must be at least 1.
- N_CH, 2, number of independent channels; must be at least 1.
- O, localparam = 1 << C, one-hot width per channel; not overridable.
- LEGAL, O, number of legal select codes (1..O); codes >= LEGAL are illegal.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high. This is fixed.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_sel  in  N_CH*C  packed selects; channel k is in_sel[k*C +: C].
- in_en  in  N_CH  per-channel enable; a disabled channel decodes to all-zero.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_onehot  out  N_CH*O  packed one-hot vectors; channel k is out_onehot[k*O +: O].
- out_any  out  N_CH  per channel, OR-reduction of that channel's out_onehot.
- mask_clr  in  1  clears the sticky hit mask.
- hit_mask  out  N_CH*O  sticky OR of all popped out_onehot values since reset or clear.
- err  out  N_CH  illegal-select flag per channel (see Optional Feature).

Behaviour:
- Reset, synchronous to clk: occupancy 0, out_valid 0, out_onehot 0, out_any 0, hit_mask 0, err 0. in_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation: buffered beats are dropped, and a clear asserted in the same cycle is irrelevant.
- Decode:
  - If in_en[k] is set, channel k output = 1 << sel_k, with the shift done at O bits (no truncation).
  - If in_en[k] is clear, channel k output = 0.
  - Decode happens on the input side; stored entries hold decoded data plus out_any and err.
- Skid buffer: 2 entries, occupancy 0..2.
  - in_ready = (occupancy < 2). It is registered-equivalent and does not depend combinationally on out_ready.
  - Push on in_valid & in_ready; pop on out_valid & out_ready.
  - Simultaneous push and pop leaves occupancy unchanged; order is FIFO.
  - A push while full is impossible (in_ready = 0). A pop while empty is impossible (out_valid = 0).
- Latency: a beat accepted at edge t is visible on out_valid/out_onehot after edge t, i.e. in cycle t+1. There is no combinational in-to-out path.
- Throughput: 1 beat/cycle sustained while out_ready is held high.
- Output stability: while out_valid & ~out_ready, out_onehot, out_any and err hold their values.
- hit_mask update, on each edge:
  - next = (mask_clr ? 0 : hit_mask) | (pop ? out_onehot : 0).
  - Clear and pop in the same cycle therefore leave exactly the popped value.
  - hit_mask is independent of buffer flow control.
- Width rules: all indexing is via the packed slices defined in Ports. With C = 1, O = 2.

Optional Feature:
- Macro: ONEHOT_DEC_ERR_EN.
- Defined:
  - err[k] = in_en[k] & (sel_k >= LEGAL), captured with the beat and presented with it.
  - An illegal channel's one-hot is forced to 0 and does not affect hit_mask.
- Undefined:
  - err is tied to 0 and LEGAL is ignored.
  - All O codes decode normally.

Decomposition:
- Package onehot_dec_pkg:
  - function onehot_w(c) returning 1 << c;
  - function decode(sel, en) returning an O-bit vector;
  - constant SKID_DEPTH = 2.
- Sub-module onehot_dec_skid: a generic 2-entry valid/ready skid buffer, parametrised by data width. Here the data width is N_CH*O + 2*N_CH. It holds all occupancy and handshake logic.
- The top level holds the decode, error logic and hit_mask.

Test Plan:
- Basic decode (C=2, N_CH=2, out_ready=1): sel={ch1=2'd1, ch0=2'd3}, en=2'b11 -> next cycle out_onehot=8'b0010_1000, out_any=2'b11, out_valid=1 for 1 cycle.
- Disable: en=2'b01, sel ch1=2'd2, ch0=2'd0 -> out_onehot=8'b0000_0001, out_any=2'b01.
- Backpressure: out_ready=0 and 3 beats offered -> 2 accepted, in_ready=0 from the 3rd cycle, out_onehot stable. Release out_ready -> beats emerge in FIFO order with no loss or duplicate.
- Sticky mask: pop ch0 codes 0 and 2 -> hit_mask[3:0]=4'b0101. mask_clr together with a pop of code 3 -> hit_mask[3:0]=4'b1000.
- Reset mid-flight: 2 beats buffered, assert rst for 1 cycle -> out_valid=0, hit_mask=0, in_ready=1 on the next cycle.
- With ONEHOT_DEC_ERR_EN, LEGAL=3: ch0 sel=3, en=1 -> err[0]=1, ch0 one-hot=0, hit_mask unchanged. Without the macro -> err=0 and one-hot=4'b1000.
